// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types and constants for the destination tracker and bypass consumer
package pipe_hazard_pkg;

   // Default register-address width; the record layout below uses it.
   localparam int REG_W = 5;

   // Register $0: never a real destination, never a hazard source.
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   // Load-use stall sequencer states.
   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } hold_state_e;

   // ID/EX stage record at the default address width.
   typedef struct packed {
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
      logic             reg_write;
      logic             mem_read;
   } stage_rec_t;

   // A bubble is an all-zero record: no destination, no write, no load.
   localparam stage_rec_t STAGE_BUBBLE = '0;

   // Bypass mux select codes used by the forwarding consumer.
   localparam logic [1:0] BYP_IDEX  = 2'b00;
   localparam logic [1:0] BYP_WB    = 2'b01;
   localparam logic [1:0] BYP_EXMEM = 2'b10;

endpackage

// File: rtl/pipe_dest_stage.sv
// rtl/pipe_dest_stage.sv - one pipeline stage register with load and bubble controls
module pipe_dest_stage
   import pipe_hazard_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic         i_bubble,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Bubble wins over load so a stall or flush always squashes the slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_bubble) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_dest_tracker.sv
// rtl/pipe_dest_tracker.sv - EX/MEM/WB destination tracker with load-use stall; option PIPE_STALL_STATS_EN adds stall/flush counters
module pipe_dest_tracker
   import pipe_hazard_pkg::*;
#(
   parameter int REG_ADDR_W        = 5,
   parameter int LOAD_STALL_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   output logic [REG_ADDR_W-1:0] ID_EX_Rs,
   output logic [REG_ADDR_W-1:0] ID_EX_Rt,
   output logic [REG_ADDR_W-1:0] ID_EX_Rd,
   output logic                  ID_EX_MemRead,
   output logic [REG_ADDR_W-1:0] EX_MEM_Rd,
   output logic                  EX_MEM_RegWrite,
   output logic [REG_ADDR_W-1:0] MEM_WB_Rd,
   output logic                  MEM_WB_RegWrite,
   output logic                  stall
`ifdef PIPE_STALL_STATS_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_count
`endif
);

   localparam int                  REC_W  = 3 * REG_ADDR_W + 2;
   localparam int                  DST_W  = REG_ADDR_W + 1;
   localparam logic [REG_ADDR_W-1:0] W_ZERO = REG_ADDR_W'(REG_ZERO);
   localparam logic [2:0]          HOLD_LOAD = 3'(LOAD_STALL_CYCLES - 1);

   hold_state_e           r_state;
   hold_state_e           w_state_nxt;
   logic [2:0]            r_cnt;
   logic [2:0]            w_cnt_nxt;
   logic                  w_stall;
   logic                  w_bubble;
   logic                  w_hazard;

   logic [REC_W-1:0]      w_id_rec;
   logic [REC_W-1:0]      w_idex_q;
   logic [DST_W-1:0]      w_exmem_q;
   logic [DST_W-1:0]      w_memwb_q;

   logic [REG_ADDR_W-1:0] w_idex_rd;
   logic                  w_idex_rw;
   logic                  w_idex_mr;

   // A write to $0 is dropped here so downstream stages never advertise it.
   assign w_id_rec = {id_rs, id_rt, id_rd,
                      id_reg_write & (id_rd != W_ZERO),
                      id_mem_read};

   assign ID_EX_Rs  = w_idex_q[REC_W-1 -: REG_ADDR_W];
   assign ID_EX_Rt  = w_idex_q[REC_W-1-REG_ADDR_W -: REG_ADDR_W];
   assign w_idex_rd = w_idex_q[REC_W-1-2*REG_ADDR_W -: REG_ADDR_W];
   assign w_idex_rw = w_idex_q[1];
   assign w_idex_mr = w_idex_q[0];

   assign ID_EX_Rd      = w_idex_rd;
   assign ID_EX_MemRead = w_idex_mr;

   assign EX_MEM_Rd       = w_exmem_q[DST_W-1:1];
   assign EX_MEM_RegWrite = w_exmem_q[0];
   assign MEM_WB_Rd       = w_memwb_q[DST_W-1:1];
   assign MEM_WB_RegWrite = w_memwb_q[0];

   // Load in EX whose destination feeds the instruction sitting in ID.
   assign w_hazard = w_idex_mr & (w_idex_rd != W_ZERO) &
                     ((w_idex_rd == id_rs) | (w_idex_rd == id_rt));

   // ID/EX takes a bubble on every stall or flush cycle.
   pipe_dest_stage #(.W(REC_W)) u_idex (
      .clk      (clk),
      .reset    (reset),
      .i_load   (1'b1),
      .i_bubble (w_bubble),
      .i_d      (w_id_rec),
      .o_q      (w_idex_q)
   );

   // Later stages keep draining through a stall.
   pipe_dest_stage #(.W(DST_W)) u_exmem (
      .clk      (clk),
      .reset    (reset),
      .i_load   (1'b1),
      .i_bubble (1'b0),
      .i_d      ({w_idex_rd, w_idex_rw}),
      .o_q      (w_exmem_q)
   );

   pipe_dest_stage #(.W(DST_W)) u_memwb (
      .clk      (clk),
      .reset    (reset),
      .i_load   (1'b1),
      .i_bubble (1'b0),
      .i_d      (w_exmem_q),
      .o_q      (w_memwb_q)
   );

   // Stall sequencer state and remaining-bubble counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Flush overrides everything; HOLD ignores the hazard and just counts down.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_bubble    = 1'b0;
      if (flush) begin
         w_bubble    = 1'b1;
         w_state_nxt = RUN;
         w_cnt_nxt   = 3'd0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_hazard) begin
                  w_stall  = 1'b1;
                  w_bubble = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     w_state_nxt = HOLD;
                     w_cnt_nxt   = HOLD_LOAD;
                  end
               end
            end
            HOLD: begin
               w_stall   = 1'b1;
               w_bubble  = 1'b1;
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  w_state_nxt = RUN;
               end
            end
            default: begin
               w_state_nxt = RUN;
               w_cnt_nxt   = 3'd0;
            end
         endcase
      end
   end

   assign stall = w_stall & ~reset;

`ifdef PIPE_STALL_STATS_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;

   // Free-running event counters; natural 32-bit wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= 32'd0;
         r_flush_count  <= 32'd0;
      end else begin
         if (stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (flush) begin
            r_flush_count <= r_flush_count + 32'd1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// tb/tb_pipe_dest_tracker.sv - directed self-checking bench for pipe_dest_tracker
module tb_pipe_dest_tracker;

   logic       clk;
   logic       reset;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       flush;

   logic [4:0] a_idex_rs, a_idex_rt, a_idex_rd, a_exmem_rd, a_memwb_rd;
   logic       a_idex_mr, a_exmem_rw, a_memwb_rw, a_stall;
   logic [4:0] b_idex_rs, b_idex_rt, b_idex_rd, b_exmem_rd, b_memwb_rd;
   logic       b_idex_mr, b_exmem_rw, b_memwb_rw, b_stall;
`ifdef PIPE_STALL_STATS_EN
   logic [31:0] a_stall_cycles, a_flush_count, b_stall_cycles, b_flush_count;
`endif

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_dest_tracker #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) u_dut1 (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_rd           (id_rd),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .flush           (flush),
      .ID_EX_Rs        (a_idex_rs),
      .ID_EX_Rt        (a_idex_rt),
      .ID_EX_Rd        (a_idex_rd),
      .ID_EX_MemRead   (a_idex_mr),
      .EX_MEM_Rd       (a_exmem_rd),
      .EX_MEM_RegWrite (a_exmem_rw),
      .MEM_WB_Rd       (a_memwb_rd),
      .MEM_WB_RegWrite (a_memwb_rw),
      .stall           (a_stall)
`ifdef PIPE_STALL_STATS_EN
      ,
      .stall_cycles    (a_stall_cycles),
      .flush_count     (a_flush_count)
`endif
   );

   pipe_dest_tracker #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) u_dut3 (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_rd           (id_rd),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .flush           (flush),
      .ID_EX_Rs        (b_idex_rs),
      .ID_EX_Rt        (b_idex_rt),
      .ID_EX_Rd        (b_idex_rd),
      .ID_EX_MemRead   (b_idex_mr),
      .EX_MEM_Rd       (b_exmem_rd),
      .EX_MEM_RegWrite (b_exmem_rw),
      .MEM_WB_Rd       (b_memwb_rd),
      .MEM_WB_RegWrite (b_memwb_rw),
      .stall           (b_stall)
`ifdef PIPE_STALL_STATS_EN
      ,
      .stall_cycles    (b_stall_cycles),
      .flush_count     (b_flush_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic mr);
      id_rs        = rs;
      id_rt        = rt;
      id_rd        = rd;
      id_reg_write = rw;
      id_mem_read  = mr;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      flush  = 1'b0;
      reset  = 1'b1;
      set_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b1);

      // reset held two cycles with live inputs
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_idex_rs", 32'(a_idex_rs), 32'd0);
      chk("rst_idex_rt", 32'(a_idex_rt), 32'd0);
      chk("rst_idex_rd", 32'(a_idex_rd), 32'd0);
      chk("rst_idex_mr", 32'(a_idex_mr), 32'd0);
      chk("rst_exmem",   32'({a_exmem_rd, a_exmem_rw}), 32'd0);
      chk("rst_memwb",   32'({a_memwb_rd, a_memwb_rw}), 32'd0);
      chk("rst_stall",   32'(a_stall), 32'd0);
      chk("rst_stall3",  32'(b_stall), 32'd0);

      // back-to-back ALU ops: $8 produced then consumed
      set_id(5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
      tick();
      chk("alu_idex_rd", 32'(a_idex_rd), 32'd8);
      set_id(5'd8, 5'd2, 5'd10, 1'b1, 1'b0);
      chk("alu_stall0", 32'(a_stall), 32'd0);
      tick();
      chk("alu_idex_rs",   32'(a_idex_rs), 32'd8);
      chk("alu_exmem_rd",  32'(a_exmem_rd), 32'd8);
      chk("alu_exmem_rw",  32'(a_exmem_rw), 32'd1);
      chk("alu_stall1",    32'(a_stall), 32'd0);

      // lw $9 then add using $9 as rt, single bubble
      do_reset();
      set_id(5'd1, 5'd0, 5'd9, 1'b1, 1'b1);
      tick();
      chk("lw_idex_mr", 32'(a_idex_mr), 32'd1);
      set_id(5'd2, 5'd9, 5'd11, 1'b1, 1'b0);
      chk("lw_stall_on", 32'(a_stall), 32'd1);
      tick();
      chk("lw_bubble", 32'({a_idex_rs, a_idex_rt, a_idex_rd, a_idex_mr}), 32'd0);
      chk("lw_exmem_rd", 32'(a_exmem_rd), 32'd9);
      chk("lw_stall_off", 32'(a_stall), 32'd0);
      tick();
      chk("lw_idex_rt",  32'(a_idex_rt), 32'd9);
      chk("lw_idex_rd",  32'(a_idex_rd), 32'd11);
      chk("lw_exmem_bub", 32'({a_exmem_rd, a_exmem_rw}), 32'd0);
      chk("lw_memwb_rd", 32'(a_memwb_rd), 32'd9);
      chk("lw_memwb_rw", 32'(a_memwb_rw), 32'd1);

      // three-bubble load-use on the second instance
      do_reset();
      set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
      chk("h3_stall_c1", 32'(b_stall), 32'd1);
      tick();
      chk("h3_stall_c2", 32'(b_stall), 32'd1);
      chk("h3_bub1", 32'({b_idex_rs, b_idex_rd, b_idex_mr}), 32'd0);
      chk("h3_exmem_rd", 32'(b_exmem_rd), 32'd5);
      tick();
      chk("h3_stall_c3", 32'(b_stall), 32'd1);
      chk("h3_bub2", 32'({b_idex_rs, b_idex_rd, b_idex_mr}), 32'd0);
      chk("h3_memwb_rd", 32'(b_memwb_rd), 32'd5);
      tick();
      chk("h3_stall_end", 32'(b_stall), 32'd0);
      chk("h3_bub3", 32'({b_idex_rs, b_idex_rd, b_idex_mr}), 32'd0);
      tick();
      chk("h3_adv_rs", 32'(b_idex_rs), 32'd5);
      chk("h3_adv_rd", 32'(b_idex_rd), 32'd7);
      chk("h3_adv_stall", 32'(b_stall), 32'd0);

      // flush on the second HOLD cycle
      do_reset();
      set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
      chk("fl_stall_run", 32'(b_stall), 32'd1);
      tick();
      chk("fl_stall_hold1", 32'(b_stall), 32'd1);
      tick();
      flush = 1'b1;
      #1;
      chk("fl_stall_flush", 32'(b_stall), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      chk("fl_bubble", 32'({b_idex_rs, b_idex_rt, b_idex_rd, b_idex_mr}), 32'd0);
      chk("fl_stall_after", 32'(b_stall), 32'd0);
      tick();
      chk("fl_adv_rs", 32'(b_idex_rs), 32'd5);
      chk("fl_adv_stall", 32'(b_stall), 32'd0);

      // register $0 as destination
      do_reset();
      set_id(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      tick();
      chk("z_idex_mr", 32'(a_idex_mr), 32'd1);
      set_id(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      chk("z_no_stall", 32'(a_stall), 32'd0);
      tick();
      chk("z_exmem_rw_lw", 32'(a_exmem_rw), 32'd0);
      set_id(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      tick();
      chk("z_exmem_rw_alu", 32'(a_exmem_rw), 32'd0);
      chk("z_memwb_rw", 32'(a_memwb_rw), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
